// File: rtl/mulu_x3y3_seq.sv
`default_nettype none
// ============================================================================
// Module   : mulu_x3y3_seq
// Purpose  : Sequencing / result-capture stage around the combinational 3x3
//            unsigned multiplier core. Accepts an operand pair over a
//            valid/ready handshake, drives the core from registers, waits a
//            programmable settle time, captures the product and offers it
//            downstream over a second valid/ready handshake.
// Options  : MULU_ACCUM_EN - adds an ACC_WIDTH-bit wrapping accumulator and
//            the acc_clr port; out_p then carries the running sum.
// Revision : 1.0 - initial release
// ============================================================================
module mulu_x3y3_seq #(
  parameter int X_WIDTH       = 3,
  parameter int Y_WIDTH       = 3,
  parameter int P_WIDTH       = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int ACC_WIDTH     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_WIDTH-1:0] in_x,
  input  logic [Y_WIDTH-1:0] in_y,
  output logic [X_WIDTH-1:0] mul_x,
  output logic [Y_WIDTH-1:0] mul_y,
  input  logic [P_WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MULU_ACCUM_EN
  output logic [ACC_WIDTH-1:0] out_p,
  input  logic                 acc_clr
`else
  output logic [P_WIDTH-1:0]   out_p
`endif
);

  // Reject configurations the stage cannot honour (4-bit counter, core width).
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || ACC_WIDTH < P_WIDTH ||
      P_WIDTH != X_WIDTH + Y_WIDTH) begin : g_bad_params
    $error("mulu_x3y3_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       capture;

  // Capture happens on the last settle edge, when the countdown has expired.
  assign capture = (state == SETTLE) && (cnt == 4'd0);

`ifdef MULU_ACCUM_EN
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] result_next;

  // A clear coinciding with capture restarts the sum from this product.
  assign acc_base    = acc_clr ? '0 : acc;
  assign result_next = acc_base + ACC_WIDTH'(mul_p);

  // Accumulator: add on capture, otherwise clear on request; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (capture) begin
      acc <= result_next;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end
`else
  logic [P_WIDTH-1:0] result_next;

  assign result_next = mul_p;
`endif

  // Control FSM with registered handshake outputs, operand and result regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_x    <= in_x;
            mul_y    <= in_y;
            cnt      <= CNT_LOAD;
            in_ready <= 1'b0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (capture) begin
            out_p     <= result_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          // No bypass: the next operand is taken only after a full IDLE cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mulu_x3y3_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mulu_x3y3_seq
// Purpose  : Directed self-checking bench for mulu_x3y3_seq. A main instance
//            (settle 2) covers handshakes, backpressure and reset; two extra
//            instances (settle 1 and 15) cover the latency sweep. The
//            accumulate scenario runs when MULU_ACCUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mulu_x3y3_seq;

`ifdef MULU_ACCUM_EN
  localparam int OUT_W = 8;
`else
  localparam int OUT_W = 6;
`endif
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic acc_clr = 1'b1;

  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0] in_x = '0, in_y = '0, mul_x, mul_y;
  logic [5:0] mul_p;
  logic [OUT_W-1:0] out_p;

  logic in_valid_s = 1'b0;
  logic in_ready1, out_valid1, in_ready15, out_valid15;
  logic [2:0] mul_x1, mul_y1, mul_x15, mul_y15;
  logic [5:0] mul_p1, mul_p15;
  logic [OUT_W-1:0] out_p1, out_p15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural stand-ins for the combinational multiplier core.
  assign mul_p   = {3'b000, mul_x}   * {3'b000, mul_y};
  assign mul_p1  = {3'b000, mul_x1}  * {3'b000, mul_y1};
  assign mul_p15 = {3'b000, mul_x15} * {3'b000, mul_y15};

  mulu_x3y3_seq #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MULU_ACCUM_EN
    .acc_clr(acc_clr),
`endif
    .out_p(out_p)
  );

  mulu_x3y3_seq #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready1),
    .in_x(in_x), .in_y(in_y), .mul_x(mul_x1), .mul_y(mul_y1), .mul_p(mul_p1),
    .out_valid(out_valid1), .out_ready(1'b1),
`ifdef MULU_ACCUM_EN
    .acc_clr(acc_clr),
`endif
    .out_p(out_p1)
  );

  mulu_x3y3_seq #(.SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready15),
    .in_x(in_x), .in_y(in_y), .mul_x(mul_x15), .mul_y(mul_y15), .mul_p(mul_p15),
    .out_valid(out_valid15), .out_ready(1'b1),
`ifdef MULU_ACCUM_EN
    .acc_clr(acc_clr),
`endif
    .out_p(out_p15)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main instance with out_ready held high.
  task automatic run_txn(input logic [2:0] x, input logic [2:0] y,
                         input logic [OUT_W-1:0] exp, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    out_ready = 1'b1;
    in_x = x; in_y = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    checks++;
    if (n != S) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, S);
    end
    checks++;
    if (out_p !== exp) begin
      errors++;
      $display("FAIL %s out_p: got %0d, expected %0d", name, out_p, exp);
    end
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0 ||
        mul_x !== 3'd0 || mul_y !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_p=%0d mul_x=%0d mul_y=%0d, expected 1 0 0 0 0",
               in_ready, out_valid, out_p, mul_x, mul_y);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_latency;
    out_ready = 1'b1;
    in_x = 3'd3; in_y = 3'd5; in_valid = 1'b1;
    tick();  // E0
    in_valid = 1'b0;
    checks++;
    if (mul_x !== 3'd3 || mul_y !== 3'd5 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: mul_x=%0d mul_y=%0d in_ready=%b out_valid=%b, expected 3 5 0 0",
               mul_x, mul_y, in_ready, out_valid);
    end
    tick();  // E0+1
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%b, expected 0", out_valid);
    end
    tick();  // E0+2
    checks++;
    if (out_valid !== 1'b1 || out_p !== OUT_W'(15)) begin
      errors++;
      $display("FAIL basic_result: out_valid=%b out_p=%0d, expected 1 15", out_valid, out_p);
    end
    tick();  // E0+3
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_return: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_operands;
    run_txn(3'd7, 3'd7, OUT_W'(49), "max_7x7");
    run_txn(3'd0, 3'd7, OUT_W'(0), "zero_0x7");
    run_txn(3'd7, 3'd1, OUT_W'(7), "ident_7x1");
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    out_ready = 1'b0;
    in_x = 3'd6; in_y = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_x = 3'd1; in_y = 3'd1; in_valid = 1'b1; end
      else in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_p !== OUT_W'(24) || in_ready !== 1'b0 ||
          mul_x !== 3'd6 || mul_y !== 3'd4) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b out_p=%0d in_ready=%b mul=%0dx%0d, expected 1 24 0 6x4",
                 i, out_valid, out_p, in_ready, mul_x, mul_y);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_x !== 3'd6 || mul_y !== 3'd4) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b mul=%0dx%0d, expected 0 1 6x4",
               out_valid, in_ready, mul_x, mul_y);
    end
    run_txn(3'd2, 3'd3, OUT_W'(6), "after_backpressure_2x3");
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    out_ready = 1'b1;
    in_x = 3'd5; in_y = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0 || mul_x !== 3'd0 || mul_y !== 3'd0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: out_valid=%b out_p=%0d mul=%0dx%0d in_ready=%b, expected 0 0 0x0 1",
               out_valid, out_p, mul_x, mul_y, in_ready);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_result: out_valid seen high %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_settle_sweep;
    int n1, n15;
    logic [OUT_W-1:0] p1, p15;
    n1 = -1; n15 = -1; p1 = '0; p15 = '0;
    in_x = 3'd2; in_y = 3'd3; in_valid_s = 1'b1;
    tick();
    in_valid_s = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out_valid1 === 1'b1 && n1 < 0) begin n1 = i; p1 = out_p1; end
      if (out_valid15 === 1'b1 && n15 < 0) begin n15 = i; p15 = out_p15; end
    end
    checks++;
    if (n1 != 1 || p1 !== OUT_W'(6)) begin
      errors++;
      $display("FAIL settle_1: valid after %0d edges out_p=%0d, expected 1 edges 6", n1, p1);
    end
    checks++;
    if (n15 != 15 || p15 !== OUT_W'(6)) begin
      errors++;
      $display("FAIL settle_15: valid after %0d edges out_p=%0d, expected 15 edges 6", n15, p15);
    end
  endtask

`ifdef MULU_ACCUM_EN
  task automatic test_accumulate;
    int n;
    tick();  // acc_clr still high: accumulator starts from zero
    acc_clr = 1'b0;
    run_txn(3'd7, 3'd7, 8'd49,  "acc_1");
    run_txn(3'd7, 3'd7, 8'd98,  "acc_2");
    run_txn(3'd7, 3'd7, 8'd147, "acc_3");
    run_txn(3'd7, 3'd7, 8'd196, "acc_4");
    run_txn(3'd7, 3'd7, 8'd245, "acc_5");
    run_txn(3'd7, 3'd7, 8'd38,  "acc_6_wrap");
    in_x = 3'd2; in_y = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    acc_clr = 1'b1;  // present during the capture edge
    tick();
    acc_clr = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_p !== 8'd6) begin
      errors++;
      $display("FAIL acc_clr_on_capture: out_valid=%b out_p=%0d, expected 1 6", out_valid, out_p);
    end
    tick();
    run_txn(3'd1, 3'd4, 8'd10, "acc_after_clr");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_latency();
    test_operands();
    test_backpressure();
    test_reset_mid();
    test_settle_sweep();
`ifdef MULU_ACCUM_EN
    test_accumulate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
